// File: rtl/booth_pkg.sv
// Shared state encodings and count-width helper for the sequential Booth multiplier.
package booth_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int booth_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int BOOTH_DEF_WIDTH = 8;
  localparam int BOOTH_CNT_W     = booth_cnt_w(BOOTH_DEF_WIDTH);

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/subtract for the Booth partial-product accumulator.
module booth_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_y
);

  assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Radix-2 sequential Booth multiplier, one recoding step per clock.
// Optional build macro BOOTH_ZERO_SKIP_EN: zero operands finish in DONE without running.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one add/sub + arithmetic shift per edge, WIDTH edges total
// DONE  | product valid, single-cycle done pulse, then back to IDLE
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = booth_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]         r_state;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_1;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic               w_sub;
  logic               w_op;
  logic               w_zero;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_a_pre;
  logic [WIDTH:0]     w_a_sh;
  logic [WIDTH-1:0]   w_q_sh;

  // 10 -> subtract M, 01 -> add M, 00/11 -> keep A
  assign w_sub = r_q[0] & ~r_q_1;
  assign w_op  = r_q[0] ^ r_q_1;

  booth_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .i_a   (r_a),
    .i_b   (r_m),
    .i_sub (w_sub),
    .o_y   (w_sum)
  );

  assign w_a_pre = w_op ? w_sum : r_a;
  assign w_a_sh  = {w_a_pre[WIDTH], w_a_pre[WIDTH:1]};
  assign w_q_sh  = {w_a_pre[0], r_q[WIDTH-1:1]};

`ifdef BOOTH_ZERO_SKIP_EN
  assign w_zero = (multiplicand == '0) || (multiplier == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_q_1   <= 1'b0;
            r_m     <= {multiplicand[WIDTH-1], multiplicand};
            r_count <= CNT_LOAD;
            if (w_zero) begin
              r_product <= '0;
              r_state   <= ST_DONE;
            end else begin
              r_state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_a     <= w_a_sh;
          r_q     <= w_q_sh;
          r_q_1   <= r_q[0];
          r_count <= r_count - CNT_ONE;
          if (r_count == CNT_ONE) begin
            r_product <= {w_a_sh[WIDTH-1:0], w_q_sh};
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule
